// File: rtl/mux_path_pkg.sv
// Shared types and constants for the mux_path_sched block.
package mux_path_pkg;

  localparam int NUM_REQ = 3;

  // Path select codes understood by path_sel3
  localparam logic [3:0] SEL_SRC0    = 4'h1;
  localparam logic [3:0] SEL_SRC1    = 4'h2;
  localparam logic [3:0] SEL_DEFAULT = 4'h0;

  typedef enum logic {IDLE, FULL} state_t;

  typedef logic [2:0] grant_t;

  // Requester index + 1, modulo 3
  function automatic logic [1:0] wrap_inc(input logic [1:0] idx);
    return (idx == 2'd2) ? 2'd0 : idx + 2'd1;
  endfunction

endpackage

// File: rtl/path_sel3.sv
// 3-way result-select datapath. Source 0 needs both its code and the enable;
// source 2 is the default path, taken for every other encoding.
module path_sel3
  import mux_path_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic [3:0]        sel_i,
  input  logic              en_i,
  input  logic [DATA_W-1:0] d0_i,
  input  logic [DATA_W-1:0] d1_i,
  input  logic [DATA_W-1:0] d2_i,
  output logic [DATA_W-1:0] y_o
);

  // Decode the select/enable pair into one of the three payloads
  always_comb begin
    y_o = d2_i;
    if (sel_i == SEL_SRC0 && en_i) y_o = d0_i;
    else if (sel_i == SEL_SRC1)    y_o = d1_i;
  end

endmodule

// File: rtl/mux_path_sched.sv
// Round-robin scheduler sharing the 3-way result-select path among three
// requesters, feeding a one-entry valid/ready output register.
// Optional burst lock: define MUX_PATH_SCHED_BURST_LOCK_EN to let a requester
// keep the path for up to MAX_BURST consecutive transfers.
module mux_path_sched
  import mux_path_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int MAX_BURST = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [2:0]            req_valid_i,
  input  logic [3*DATA_W-1:0]   req_data_i,
  output logic [2:0]            req_ready_o,
  output logic [3:0]            sel_o,
  output logic                  en_o,
  output logic [2:0]            grant_o,
  output logic                  result_valid_o,
  output logic [DATA_W-1:0]     result_o,
  input  logic                  result_ready_i
);

  state_t            state_q;
  logic              rvalid_q;
  logic [DATA_W-1:0] result_q;
  logic [1:0]        rr_ptr_q;   // index of the last granted requester

  logic              can_accept;
  logic              grant_vld;
  logic [1:0]        grant_idx;
  logic [1:0]        c0, c1, c2;
  grant_t            grant;
  logic [DATA_W-1:0] sel_data;

  assign can_accept = (state_q == IDLE) || result_ready_i;

`ifdef MUX_PATH_SCHED_BURST_LOCK_EN
  localparam int CNT_W = $clog2(MAX_BURST + 1);
  logic [CNT_W-1:0] burst_cnt_q;
  logic             lock_active;
  // Holder keeps priority while its burst is started and not yet exhausted
  assign lock_active = (burst_cnt_q != '0) && (burst_cnt_q < CNT_W'(MAX_BURST));
`else
  logic unused_max_burst;
  assign unused_max_burst = (MAX_BURST > 0);
`endif

  // Arbitration: search rr_ptr+1, rr_ptr+2, rr_ptr when the output can take data
  always_comb begin
    c0        = wrap_inc(rr_ptr_q);
    c1        = wrap_inc(c0);
    c2        = rr_ptr_q;
    grant_vld = 1'b0;
    grant_idx = 2'd0;
    if (can_accept) begin
      if (req_valid_i[c0]) begin
        grant_vld = 1'b1;
        grant_idx = c0;
      end else if (req_valid_i[c1]) begin
        grant_vld = 1'b1;
        grant_idx = c1;
      end else if (req_valid_i[c2]) begin
        grant_vld = 1'b1;
        grant_idx = c2;
      end
`ifdef MUX_PATH_SCHED_BURST_LOCK_EN
      if (lock_active && req_valid_i[rr_ptr_q]) begin
        grant_vld = 1'b1;
        grant_idx = rr_ptr_q;
      end
`endif
    end
  end

  assign grant       = grant_vld ? (grant_t'(1) << grant_idx) : '0;
  assign grant_o     = grant;
  assign req_ready_o = grant;

  // Path encoding; grant 2 rides the default path
  always_comb begin
    sel_o = SEL_DEFAULT;
    en_o  = 1'b0;
    if (grant_vld && grant_idx == 2'd0) begin
      sel_o = SEL_SRC0;
      en_o  = 1'b1;
    end else if (grant_vld && grant_idx == 2'd1) begin
      sel_o = SEL_SRC1;
    end
  end

  path_sel3 #(.DATA_W(DATA_W)) u_path (
    .sel_i (sel_o),
    .en_i  (en_o),
    .d0_i  (req_data_i[0*DATA_W +: DATA_W]),
    .d1_i  (req_data_i[1*DATA_W +: DATA_W]),
    .d2_i  (req_data_i[2*DATA_W +: DATA_W]),
    .y_o   (sel_data)
  );

  // FSM and output register: load on grant, empty on drain without grant
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      rvalid_q <= 1'b0;
      result_q <= '0;
      rr_ptr_q <= 2'd2;
    end else begin
      if (state_q == IDLE) begin
        if (grant_vld) state_q <= FULL;
      end else begin
        if (!grant_vld && result_ready_i) state_q <= IDLE;
      end
      if (grant_vld) begin
        result_q <= sel_data;
        rvalid_q <= 1'b1;
        rr_ptr_q <= grant_idx;
      end else if (state_q == FULL && result_ready_i) begin
        rvalid_q <= 1'b0;
      end
    end
  end

`ifdef MUX_PATH_SCHED_BURST_LOCK_EN
  // Burst counter: advances only on transfers that continue the holder's burst
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      burst_cnt_q <= '0;
    end else if (grant_vld) begin
      if (lock_active && grant_idx == rr_ptr_q) burst_cnt_q <= burst_cnt_q + CNT_W'(1);
      else                                      burst_cnt_q <= CNT_W'(1);
    end
  end
`endif

  assign result_valid_o = rvalid_q;
  assign result_o       = result_q;

endmodule

// File: tb/tb_mux_path_sched.sv
// Self-checking bench for mux_path_sched: expected results are queued as
// grants happen and popped when the consumer drains the output register.
module tb_mux_path_sched;

  localparam int DW = 8;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic [2:0]    req_valid_i;
  logic [3*DW-1:0] req_data_i;
  logic [2:0]    req_ready_o;
  logic [3:0]    sel_o;
  logic          en_o;
  logic [2:0]    grant_o;
  logic          result_valid_o;
  logic [DW-1:0] result_o;
  logic          result_ready_i;

  int total = 0;
  int bad   = 0;
  logic [DW-1:0] sbq[$];

  always #5 clk_i = ~clk_i;

  mux_path_sched #(.DATA_W(DW), .MAX_BURST(4)) dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .req_valid_i    (req_valid_i),
    .req_data_i     (req_data_i),
    .req_ready_o    (req_ready_o),
    .sel_o          (sel_o),
    .en_o           (en_o),
    .grant_o        (grant_o),
    .result_valid_o (result_valid_o),
    .result_o       (result_o),
    .result_ready_i (result_ready_i)
  );

  // Pop and compare on a drain, then advance to just after the next edge
  task automatic tick();
    logic [DW-1:0] exp;
    if (result_valid_o && result_ready_i) begin
      total++;
      if (sbq.size() == 0) begin
        bad++;
        $display("FAIL drain_unexpected got=%h", result_o);
      end else begin
        exp = sbq.pop_front();
        if (result_o !== exp) begin
          bad++;
          $display("FAIL drain_data got=%h exp=%h", result_o, exp);
        end
      end
    end
    @(posedge clk_i);
    #1;
  endtask

  task automatic test_reset();
    rst_i = 1'b1; req_valid_i = '0; req_data_i = '0; result_ready_i = 1'b0;
    repeat (2) @(posedge clk_i);
    #1; rst_i = 1'b0; #1;
    total++;
    if ({result_valid_o, result_o, grant_o, req_ready_o, sel_o, en_o} !== '0) begin
      bad++;
      $display("FAIL reset_state got v=%b r=%h g=%b rdy=%b sel=%h en=%b exp all zero",
               result_valid_o, result_o, grant_o, req_ready_o, sel_o, en_o);
    end
  endtask

  task automatic test_round_robin();
    logic [7:0] dat [3] = '{8'hAA, 8'hBB, 8'hCC};
    logic [3:0] sexp[3] = '{4'h1, 4'h2, 4'h0};
    logic       eexp[3] = '{1'b1, 1'b0, 1'b0};
    req_valid_i = 3'b111; req_data_i = {8'hCC, 8'hBB, 8'hAA}; result_ready_i = 1'b1;
    for (int i = 0; i < 6; i++) begin
      #1;
      total++;
      if (grant_o !== (3'b001 << (i % 3)) || req_ready_o !== (3'b001 << (i % 3))) begin
        bad++;
        $display("FAIL rr_grant cyc=%0d got g=%b rdy=%b exp=%b", i, grant_o, req_ready_o, 3'b001 << (i % 3));
      end
      total++;
      if (sel_o !== sexp[i % 3] || en_o !== eexp[i % 3]) begin
        bad++;
        $display("FAIL rr_path cyc=%0d got sel=%h en=%b exp sel=%h en=%b", i, sel_o, en_o, sexp[i % 3], eexp[i % 3]);
      end
      sbq.push_back(dat[i % 3]);
      tick();
      total++;
      if (result_valid_o !== 1'b1) begin
        bad++;
        $display("FAIL rr_valid cyc=%0d got=%b exp=1", i, result_valid_o);
      end
    end
    req_valid_i = '0;
    tick();
    total++;
    if (result_valid_o !== 1'b0) begin
      bad++;
      $display("FAIL rr_empty got=%b exp=0", result_valid_o);
    end
  endtask

  task automatic test_stall();
    req_valid_i = 3'b010; req_data_i = {8'h00, 8'h5A, 8'h00}; result_ready_i = 1'b0;
    #1;
    total++;
    if (grant_o !== 3'b010 || sel_o !== 4'h2 || en_o !== 1'b0) begin
      bad++;
      $display("FAIL stall_grant got g=%b sel=%h en=%b exp g=010 sel=2 en=0", grant_o, sel_o, en_o);
    end
    sbq.push_back(8'h5A);
    tick();
    for (int i = 0; i < 3; i++) begin
      total++;
      if (result_valid_o !== 1'b1 || result_o !== 8'h5A || req_ready_o !== 3'b000 || grant_o !== 3'b000) begin
        bad++;
        $display("FAIL stall_hold cyc=%0d got v=%b r=%h rdy=%b g=%b exp v=1 r=5a rdy=000 g=000",
                 i, result_valid_o, result_o, req_ready_o, grant_o);
      end
      tick();
    end
    req_valid_i = '0; result_ready_i = 1'b1;
    #1;
    tick();
    total++;
    if (result_valid_o !== 1'b0) begin
      bad++;
      $display("FAIL stall_drain got=%b exp=0", result_valid_o);
    end
  endtask

  task automatic test_back_to_back();
    req_valid_i = 3'b001; req_data_i = {8'h00, 8'h00, 8'h11}; result_ready_i = 1'b1;
    #1;
    total++;
    if (grant_o !== 3'b001) begin
      bad++;
      $display("FAIL b2b_first got=%b exp=001", grant_o);
    end
    sbq.push_back(8'h11);
    tick();
    req_valid_i = 3'b100; req_data_i = {8'h22, 8'h00, 8'h00};
    #1;
    total++;
    if (grant_o !== 3'b100 || sel_o !== 4'h0 || en_o !== 1'b0) begin
      bad++;
      $display("FAIL b2b_second got g=%b sel=%h en=%b exp g=100 sel=0 en=0", grant_o, sel_o, en_o);
    end
    sbq.push_back(8'h22);
    tick();
    total++;
    if (result_valid_o !== 1'b1 || result_o !== 8'h22) begin
      bad++;
      $display("FAIL b2b_pass got v=%b r=%h exp v=1 r=22", result_valid_o, result_o);
    end
    req_valid_i = '0;
    tick();
  endtask

  task automatic test_reset_mid();
    req_valid_i = 3'b010; req_data_i = {8'h00, 8'h77, 8'h00}; result_ready_i = 1'b0;
    #1;
    tick();
    total++;
    if (result_valid_o !== 1'b1) begin
      bad++;
      $display("FAIL rstmid_loaded got=%b exp=1", result_valid_o);
    end
    result_ready_i = 1'b1; rst_i = 1'b1;
    #1;
    total++;
    if (req_ready_o !== 3'b010) begin
      bad++;
      $display("FAIL rstmid_ready got=%b exp=010", req_ready_o);
    end
    @(posedge clk_i);
    #1; rst_i = 1'b0; req_valid_i = '0; #1;
    total++;
    if (result_valid_o !== 1'b0 || grant_o !== 3'b000 || result_o !== 8'h00) begin
      bad++;
      $display("FAIL rstmid_cleared got v=%b g=%b r=%h exp v=0 g=000 r=00", result_valid_o, grant_o, result_o);
    end
    req_valid_i = 3'b011; req_data_i = {8'h00, 8'h32, 8'h31};
    #1;
    total++;
    if (grant_o !== 3'b001) begin
      bad++;
      $display("FAIL rstmid_first got=%b exp=001", grant_o);
    end
    sbq.push_back(8'h31);
    tick();
    req_valid_i = '0;
    #1;
    tick();
  endtask

  task automatic test_idle();
    req_valid_i = '0; result_ready_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      total++;
      if (grant_o !== 3'b000 || req_ready_o !== 3'b000 || sel_o !== 4'h0 || en_o !== 1'b0 || result_valid_o !== 1'b0) begin
        bad++;
        $display("FAIL idle cyc=%0d got g=%b rdy=%b sel=%h en=%b v=%b exp all zero",
                 i, grant_o, req_ready_o, sel_o, en_o, result_valid_o);
      end
      tick();
    end
  endtask

  task automatic test_burst();
    int idx;
    rst_i = 1'b1;
    @(posedge clk_i);
    #1; rst_i = 1'b0;
    req_valid_i = 3'b011; req_data_i = {8'h00, 8'hA1, 8'hA0}; result_ready_i = 1'b1;
    for (int i = 0; i < 16; i++) begin
`ifdef MUX_PATH_SCHED_BURST_LOCK_EN
      idx = (i / 4) % 2;
`else
      idx = i % 2;
`endif
      #1;
      total++;
      if (grant_o !== (3'b001 << idx)) begin
        bad++;
        $display("FAIL burst_grant cyc=%0d got=%b exp=%b", i, grant_o, 3'b001 << idx);
      end
      sbq.push_back(idx == 0 ? 8'hA0 : 8'hA1);
      tick();
    end
    req_valid_i = '0;
    #1;
    tick();
    total++;
    if (result_valid_o !== 1'b0 || sbq.size() != 0) begin
      bad++;
      $display("FAIL burst_end got v=%b pending=%0d exp v=0 pending=0", result_valid_o, sbq.size());
    end
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_stall();
    test_back_to_back();
    test_reset_mid();
    test_idle();
    test_burst();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mux_path_sched.md
Name: mux_path_sched

Overview:
- Round-robin scheduler that shares the 3-way 8-bit result-select datapath among three requesters.
- Each cycle it picks at most one requester and drives the select/enable encoding for the path-select sub-module.
- The selected byte is captured in a one-entry output register with a valid/ready handshake.
- Sits between the three producers and the single downstream consumer of the selected result.

Parameters:
- DATA_W, 8, width of each requester payload and of result_o
- MAX_BURST, 4, maximum consecutive grants to one requester; used only when burst lock is compiled in

Ports:
- clk_i  in  1  single clock; all state updates on its rising edge
- rst_i  in  1  reset, synchronous, active-high
- req_valid_i  in  3  bit n: requester n has data
- req_data_i  in  3*DATA_W  requester n payload in bits [n*DATA_W +: DATA_W]
- req_ready_o  out  3  bit n: requester n accepted this cycle (one-hot or zero)
- sel_o  out  4  path select code driven to the datapath
- en_o  out  1  path enable driven to the datapath
- grant_o  out  3  one-hot current grant, or zero
- result_valid_o  out  1  output register holds data
- result_o  out  DATA_W  output register contents
- result_ready_i  in  1  consumer accepts result this cycle

Behaviour:
- Interface: one clock (clk_i); reset rst_i is synchronous and active-high.
- Reset values: result_valid_o=0, result_o=0, rr_ptr=2 (requester 0 has highest priority first), state=IDLE. With the state at reset, the combinational outputs evaluate to grant_o=0, req_ready_o=0, sel_o=4'h0, en_o=0.
- Path encoding:
  - grant 0 -> sel_o=4'h1, en_o=1
  - grant 1 -> sel_o=4'h2, en_o=0
  - grant 2 or no grant -> sel_o=4'h0, en_o=0 (default path)
  - Codes 4'h3 and above are never driven.
- Capacity: can_accept = !result_valid_o || result_ready_i.
- Arbitration is combinational.
  - If can_accept, grant the first valid requester searching rr_ptr+1, rr_ptr+2, rr_ptr, mod 3.
  - Otherwise grant_o=0.
  - req_ready_o equals grant_o.
- On a cycle with a grant (transfer):
  - result_o <= selected payload; result_valid_o <= 1.
  - rr_ptr <= granted index.
  - Latency: 1 cycle from transfer to result_valid_o.
- Drain without a new grant: result_valid_o <= 0 and result_o holds its value.
- A simultaneous drain and grant is a full-throughput pass: one result per cycle.
- FSM:
  - IDLE (output empty): goes to FULL on a grant.
  - FULL (output valid): goes to IDLE on a drain with no grant; stays FULL on drain+grant or on a stall.
  - In FULL with result_ready_i=0, result_o and result_valid_o are held stable and no requester is granted.
- All requesters idle: no grant, and sel_o/en_o sit at the default path.
- Wrap: rr_ptr 2 -> next search starts at 0.
- Reset mid-transfer: rst_i wins. The pending result is dropped, and a req_ready_o asserted in the same cycle has no effect.
- req_data_i of non-granted requesters is ignored.

Optional Feature:
- Macro: MUX_PATH_SCHED_BURST_LOCK_EN.
- Defined:
  - After a grant, the same requester keeps priority while its req_valid_i stays high, up to MAX_BURST consecutive transfers.
  - A burst counter counts transfers 1..MAX_BURST. When the count reaches MAX_BURST, or the holder drops valid, normal round-robin resumes from the holder.
  - Stall cycles do not advance the counter. Reset clears the counter to 0.
- Undefined: strict round-robin on every transfer, and no counter is present.

Decomposition:
- Shared package mux_path_pkg holds:
  - constants SEL_SRC0=4'h1, SEL_SRC1=4'h2, SEL_DEFAULT=4'h0, and NUM_REQ=3
  - typedef state_t {IDLE, FULL}
  - typedef grant_t logic [2:0]
- One sub-module, path_sel3: the combinational 3-way select driven by sel_o/en_o.
  - Inputs: the three payloads.
  - Output: the selected byte.
  - Instantiated inside mux_path_sched so that the encoding is exercised end to end.

Test Plan:
- Reset, then all three valid with data AA/BB/CC and result_ready_i=1 -> results AA, BB, CC, AA... on consecutive cycles; req_ready_o cycles 001, 010, 100; sel_o/en_o cycles 1/1, 2/0, 0/0.
- Only requester 1 valid with 5A and result_ready_i=0 for 3 cycles -> one transfer; result_o=5A with valid held 3 cycles; req_ready_o=0 during the stall; drain on the 4th cycle.
- Drain and a new grant in the same cycle (req0=11 then req2=22, ready=1) -> result_valid_o stays 1 and result_o goes 11 -> 22 back-to-back.
- rst_i asserted while result_valid_o=1 -> next cycle result_valid_o=0 and grant_o=0; the next grant goes to requester 0 first.
- No requests for 5 cycles -> grant_o=0, sel_o=0, en_o=0, result_valid_o=0 after the last drain.
- With MUX_PATH_SCHED_BURST_LOCK_EN, MAX_BURST=4, req0 and req1 always valid, ready=1 -> four req0 transfers, then req1 for four, then alternating bursts; without the macro -> strict alternation.
